axi_line_master: RTL and testbench

Parametrised AXI4 burst master between the cache controller and the memory-side AXI interconnect. It moves whole cache lines: write-back bursts of dirty victims and refill bursts on misses. Write-back and refill requests raised together run back-to-back, write first, then read. Address and data paths are integrated, the line is buffered internally, AW/W are handled independently, and response errors are reported.

---
 rtl/axi_line_master.sv | 202 ++++++++++++++++++++
 tb/tb_axi_line_master.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_line_master.sv
// AXI4 burst master moving whole cache lines: write-back of a buffered victim
// line and refill into rf_line; a combined request runs the write first.
module axi_line_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BEATS  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_req,
    input  logic [ADDR_W-1:0]       wb_addr,
    input  logic [BEATS*DATA_W-1:0] wb_line,
    input  logic                    rf_req,
    input  logic [ADDR_W-1:0]       rf_addr,
    output logic [BEATS*DATA_W-1:0] rf_line,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    aw_valid,
    input  logic                    aw_ready,
    output logic [ADDR_W-1:0]       aw_addr,
    output logic [7:0]              aw_len,
    output logic [2:0]              aw_size,
    output logic [1:0]              aw_burst,
    output logic                    w_valid,
    input  logic                    w_ready,
    output logic [DATA_W-1:0]       w_data,
    output logic                    w_last,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [1:0]              b_resp,
    output logic                    ar_valid,
    input  logic                    ar_ready,
    output logic [ADDR_W-1:0]       ar_addr,
    output logic [7:0]              ar_len,
    output logic [2:0]              ar_size,
    output logic [1:0]              ar_burst,
    input  logic                    r_valid,
    output logic                    r_ready,
    input  logic [DATA_W-1:0]       r_data,
    input  logic                    r_last,
    input  logic [1:0]              r_resp
);

    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(BEATS * DATA_W / 8);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
    localparam logic [CNT_W-1:0]  LAST = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  FULL = CNT_W'(BEATS);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              aw_done_q, w_done_q, rf_pend_q, err_q;
    logic              aw_valid_q, w_valid_q, b_ready_q, ar_valid_q, r_ready_q;
    logic [ADDR_W-1:0] aw_addr_q, ar_addr_q;
    logic [DATA_W-1:0] wbuf_q [BEATS];
    logic [DATA_W-1:0] rf_q   [BEATS];
    logic              aw_done_d, w_done_d, err_d;

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign err      = done & err_q;
    assign aw_valid = aw_valid_q;
    assign aw_addr  = aw_addr_q;
    assign aw_len   = 8'(BEATS - 1);
    assign aw_size  = 3'($clog2(DATA_W / 8));
    assign aw_burst = 2'b01;
    assign w_valid  = w_valid_q;
    assign w_data   = wbuf_q[cnt_q[IDX_W-1:0]];
    assign w_last   = w_valid_q & (cnt_q == LAST);
    assign b_ready  = b_ready_q;
    assign ar_valid = ar_valid_q;
    assign ar_addr  = ar_addr_q;
    assign ar_len   = 8'(BEATS - 1);
    assign ar_size  = 3'($clog2(DATA_W / 8));
    assign ar_burst = 2'b01;
    assign r_ready  = r_ready_q;

    for (genvar g = 0; g < BEATS; g++) begin : g_rf_pack
        assign rf_line[g*DATA_W +: DATA_W] = rf_q[g];
    end

    // AW and the last W beat may complete in either order or in the same cycle.
    always_comb begin
        aw_done_d = aw_done_q | (aw_valid_q & aw_ready);
        w_done_d  = w_done_q | (w_valid_q & w_ready & (cnt_q == LAST));
        err_d     = err_q;
        if (b_ready_q && b_valid && (b_resp != 2'b00))
            err_d = 1'b1;
        if (r_ready_q && r_valid && ((r_resp != 2'b00) || (r_last && (cnt_q != LAST))))
            err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            rf_pend_q  <= 1'b0;
            err_q      <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            for (int i = 0; i < BEATS; i++) rf_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (wb_req) begin
                        state_q    <= S_WR;
                        aw_valid_q <= 1'b1;
                        w_valid_q  <= 1'b1;
                        rf_pend_q  <= rf_req;
                    end else if (rf_req) begin
                        state_q    <= S_RD_ADDR;
                        ar_valid_q <= 1'b1;
                        rf_pend_q  <= 1'b0;
                    end
                end
                S_WR: begin
                    aw_done_q <= aw_done_d;
                    w_done_q  <= w_done_d;
                    if (aw_valid_q && aw_ready)
                        aw_valid_q <= 1'b0;
                    if (w_valid_q && w_ready) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST)
                            w_valid_q <= 1'b0;
                    end
                    if (aw_done_d && w_done_d) begin
                        state_q   <= S_WR_RESP;
                        b_ready_q <= 1'b1;
                        cnt_q     <= '0;
                    end
                end
                S_WR_RESP: begin
                    err_q <= err_d;
                    if (b_valid) begin
                        b_ready_q <= 1'b0;
                        if (rf_pend_q) begin
                            state_q    <= S_RD_ADDR;
                            ar_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_RD_ADDR: begin
                    if (ar_ready) begin
                        state_q    <= S_RD_DATA;
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                    end
                end
                S_RD_DATA: begin
                    err_q <= err_d;
                    // Counter saturates at BEATS so surplus beats are dropped.
                    if (r_valid) begin
                        if (cnt_q < FULL) begin
                            rf_q[cnt_q[IDX_W-1:0]] <= r_data;
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                        if (r_last) begin
                            state_q   <= S_DONE;
                            r_ready_q <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    state_q   <= S_IDLE;
                    err_q     <= 1'b0;
                    cnt_q     <= '0;
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    rf_pend_q <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Request payload is captured only on acceptance, so it stays stable while valid.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE) begin
            if (wb_req) begin
                aw_addr_q <= wb_addr & ADDR_MASK;
                ar_addr_q <= rf_addr & ADDR_MASK;
                for (int i = 0; i < BEATS; i++) wbuf_q[i] <= wb_line[i*DATA_W +: DATA_W];
            end else if (rf_req) begin
                ar_addr_q <= rf_addr & ADDR_MASK;
            end
        end
    end

endmodule

// File: tb/tb_axi_line_master.sv
// Randomized bench for axi_line_master: a behavioural AXI slave plus a
// line-level model of the expected bursts, rf_line contents and err.
module tb_axi_line_master;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BEATS  = 4;
    localparam logic [31:0] AMASK = ~32'(BEATS * DATA_W / 8 - 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wb_req = 1'b0, rf_req = 1'b0;
    logic [31:0] wb_addr = '0, rf_addr = '0;
    logic [127:0] wb_line = '0;
    logic [127:0] rf_line;
    logic busy, done, err;
    logic aw_valid, aw_ready = 1'b0;
    logic [31:0] aw_addr;
    logic [7:0] aw_len;
    logic [2:0] aw_size;
    logic [1:0] aw_burst;
    logic w_valid, w_ready = 1'b0;
    logic [31:0] w_data;
    logic w_last;
    logic b_valid = 1'b0, b_ready;
    logic [1:0] b_resp = '0;
    logic ar_valid, ar_ready = 1'b0;
    logic [31:0] ar_addr;
    logic [7:0] ar_len;
    logic [2:0] ar_size;
    logic [1:0] ar_burst;
    logic r_valid = 1'b0, r_ready;
    logic [31:0] r_data = '0;
    logic r_last = 1'b0;
    logic [1:0] r_resp = '0;

    axi_line_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
        .clk(clk), .rst(rst),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_line(wb_line),
        .rf_req(rf_req), .rf_addr(rf_addr), .rf_line(rf_line),
        .busy(busy), .done(done), .err(err),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
        .aw_size(aw_size), .aw_burst(aw_burst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
        .ar_size(ar_size), .ar_burst(ar_burst),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last), .r_resp(r_resp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc;
    bit cur_wb, cur_rf;
    logic [31:0] cur_wa, cur_ra;
    logic [31:0] cur_line [BEATS];
    logic [1:0] cur_bresp;
    int pr, aw_low_until;
    logic [31:0] rq_data [$];
    bit rq_last [$];
    logic [1:0] rq_resp [$];
    bit aw_got, wl_got, b_got, ar_got, hs_b, hs_r;
    bit p_aw_pend, p_w_pend, p_ar_pend;
    int wcnt, aw_cnt, ar_cnt, rcnt, aw_wcnt;
    bit done_seen, done_err_v;
    int done_cyc;
    logic [31:0] exp_rf [BEATS];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit rnd(input int p);
        return $urandom_range(99) < 32'(p);
    endfunction

    task automatic drive();
        aw_ready = (cyc <= aw_low_until) ? 1'b0 : rnd(pr);
        w_ready  = rnd(pr);
        ar_ready = rnd(pr);
        if (hs_b) b_valid = 1'b0;
        if (hs_r) begin
            r_valid = 1'b0;
            void'(rq_data.pop_front());
            void'(rq_last.pop_front());
            void'(rq_resp.pop_front());
        end
        hs_b = 1'b0;
        hs_r = 1'b0;
        if (!b_valid && aw_got && wl_got && !b_got && rnd(pr)) begin
            b_valid = 1'b1;
            b_resp  = cur_bresp;
        end
        if (!r_valid && ar_got && rq_data.size() > 0 && rnd(pr)) begin
            r_valid = 1'b1;
            r_data  = rq_data[0];
            r_last  = rq_last[0];
            r_resp  = rq_resp[0];
        end
    endtask

    task automatic monitor();
        if (p_aw_pend) check_eq("aw_valid_hold", 128'(aw_valid), 128'(1));
        if (p_w_pend)  check_eq("w_valid_hold", 128'(w_valid), 128'(1));
        if (p_ar_pend) check_eq("ar_valid_hold", 128'(ar_valid), 128'(1));
        if (aw_valid) check_eq("aw_addr", 128'(aw_addr), 128'(cur_wa & AMASK));
        if (ar_valid) check_eq("ar_addr", 128'(ar_addr), 128'(cur_ra & AMASK));
        if (w_valid) begin
            if (wcnt < BEATS) check_eq("w_data", 128'(w_data), 128'(cur_line[wcnt]));
            else check_eq("w_extra_beat", 128'(w_valid), 128'(0));
        end
        if (cur_wb && cur_rf && !b_got) check_eq("ar_before_b", 128'(ar_valid), 128'(0));
        if (aw_valid && aw_ready) begin
            aw_cnt++;
            aw_wcnt = wcnt;
            aw_got = 1'b1;
            check_eq("aw_len", 128'(aw_len), 128'(BEATS - 1));
            check_eq("aw_size", 128'(aw_size), 128'(2));
            check_eq("aw_burst", 128'(aw_burst), 128'(1));
        end
        if (w_valid && w_ready) begin
            check_eq("w_last", 128'(w_last), 128'(wcnt == BEATS - 1));
            wcnt++;
            if (wcnt == BEATS) wl_got = 1'b1;
        end
        if (b_valid && b_ready) begin
            b_got = 1'b1;
            hs_b = 1'b1;
        end
        if (ar_valid && ar_ready) begin
            ar_cnt++;
            ar_got = 1'b1;
            check_eq("ar_len", 128'(ar_len), 128'(BEATS - 1));
            check_eq("ar_size", 128'(ar_size), 128'(2));
            check_eq("ar_burst", 128'(ar_burst), 128'(1));
        end
        if (r_valid && r_ready) begin
            hs_r = 1'b1;
            rcnt++;
        end
        if (done) begin
            done_seen = 1'b1;
            done_err_v = err;
            done_cyc = cyc;
        end
        p_aw_pend = aw_valid && !aw_ready;
        p_w_pend  = w_valid && !w_ready;
        p_ar_pend = ar_valid && !ar_ready;
    endtask

    task automatic cycle();
        @(posedge clk); #1;
        cyc++;
        if (cyc == 1) begin
            wb_req  = 1'b0;
            rf_req  = 1'b0;
            wb_addr = $urandom;
            rf_addr = $urandom;
            wb_line = {$urandom, $urandom, $urandom, $urandom};
        end
        drive();
        @(negedge clk);
        monitor();
    endtask

    task automatic clear_bench();
        rq_data.delete(); rq_last.delete(); rq_resp.delete();
        aw_got = 0; wl_got = 0; b_got = 0; ar_got = 0; hs_b = 0; hs_r = 0;
        p_aw_pend = 0; p_w_pend = 0; p_ar_pend = 0;
        wcnt = 0; aw_cnt = 0; ar_cnt = 0; rcnt = 0; aw_wcnt = 0;
        done_seen = 0; done_err_v = 0; done_cyc = -1;
        b_valid = 0; r_valid = 0; r_last = 0;
    endtask

    task automatic run_txn(input bit wb, input bit rf, input logic [31:0] wa, input logic [31:0] ra,
                           input logic [127:0] line, input logic [31:0] rbase, input int nbeats,
                           input int rerr_beat, input logic [1:0] bresp, input int p,
                           input int aw_low, input int exp_cyc);
        bit exp_err;
        @(posedge clk); #1;
        clear_bench();
        cur_wb = wb; cur_rf = rf; cur_wa = wa; cur_ra = ra; cur_bresp = bresp;
        pr = p; aw_low_until = aw_low; cyc = 0;
        for (int k = 0; k < BEATS; k++) cur_line[k] = line[k*32 +: 32];
        exp_err = wb && (bresp != 2'b00);
        if (rf) begin
            for (int k = 0; k < nbeats; k++) begin
                rq_data.push_back(rbase + 32'(k));
                rq_last.push_back(k == nbeats - 1);
                rq_resp.push_back((k == rerr_beat) ? 2'b10 : 2'b00);
                if (k < BEATS) exp_rf[k] = rbase + 32'(k);
            end
            if (nbeats != BEATS || (rerr_beat >= 0 && rerr_beat < nbeats)) exp_err = 1'b1;
        end
        wb_req = wb; rf_req = rf; wb_addr = wa; rf_addr = ra; wb_line = line;
        drive();
        @(negedge clk);
        check_eq("idle_busy", 128'(busy), 128'(0));
        monitor();
        while (!done_seen && cyc < 400) cycle();
        check_eq("done_seen", 128'(done_seen), 128'(1));
        if (!done_seen) begin
            rst = 1'b0;
            repeat (2) @(negedge clk);
            rst = 1'b1;
            for (int k = 0; k < BEATS; k++) exp_rf[k] = '0;
            return;
        end
        check_eq("err", 128'(done_err_v), 128'(exp_err));
        if (exp_cyc >= 0) check_eq("done_cycle", 128'(done_cyc), 128'(exp_cyc));
        check_eq("aw_count", 128'(aw_cnt), 128'(wb ? 1 : 0));
        check_eq("w_count", 128'(wcnt), 128'(wb ? BEATS : 0));
        check_eq("ar_count", 128'(ar_cnt), 128'(rf ? 1 : 0));
        check_eq("r_count", 128'(rcnt), 128'(rf ? nbeats : 0));
        check_eq("rf_line", rf_line, {exp_rf[3], exp_rf[2], exp_rf[1], exp_rf[0]});
        if (wb && p == 100 && aw_low > BEATS) check_eq("w_before_aw", 128'(aw_wcnt), 128'(BEATS));
    endtask

    task automatic reset_mid_write();
        @(posedge clk); #1;
        clear_bench();
        cur_wb = 1; cur_rf = 0;
        wb_req = 1'b1; wb_addr = 32'h3000; wb_line = {$urandom, $urandom, $urandom, $urandom};
        aw_ready = 1'b1; w_ready = 1'b1;
        @(posedge clk); #1;
        wb_req = 1'b0;
        @(posedge clk); #1;
        check_eq("pre_rst_w_valid", 128'(w_valid), 128'(1));
        check_eq("pre_rst_busy", 128'(busy), 128'(1));
        #2 rst = 1'b0;
        #1;
        check_eq("rst_w_valid", 128'(w_valid), 128'(0));
        check_eq("rst_aw_valid", 128'(aw_valid), 128'(0));
        check_eq("rst_busy", 128'(busy), 128'(0));
        check_eq("rst_done", 128'(done), 128'(0));
        check_eq("rst_b_ready", 128'(b_ready), 128'(0));
        check_eq("rst_rf_line", rf_line, 128'(0));
        for (int k = 0; k < BEATS; k++) exp_rf[k] = '0;
        aw_ready = 1'b0; w_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        int nb;
        for (int k = 0; k < BEATS; k++) exp_rf[k] = '0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", 128'(busy), 128'(0));
        check_eq("reset_done", 128'(done), 128'(0));
        check_eq("reset_err", 128'(err), 128'(0));
        check_eq("reset_valids", 128'({aw_valid, w_valid, ar_valid}), 128'(0));
        check_eq("reset_readies", 128'({b_ready, r_ready}), 128'(0));
        check_eq("reset_rf_line", rf_line, 128'(0));
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_txn(1, 0, 32'h1004, 32'h0, 128'h00000044_00000033_00000022_00000011,
                32'h0, 0, -1, 2'b00, 100, -1, BEATS + 2);
        run_txn(0, 1, 32'h0, 32'h2000, 128'h0, 32'hA0, BEATS, -1, 2'b00, 100, -1, BEATS + 2);
        run_txn(1, 1, 32'h4008, 32'h5010, {$urandom, $urandom, $urandom, $urandom},
                32'hB0, BEATS, -1, 2'b00, 100, -1, 2 * BEATS + 3);
        run_txn(1, 0, 32'h6000, 32'h0, {$urandom, $urandom, $urandom, $urandom},
                32'h0, 0, -1, 2'b10, 100, 5, -1);
        run_txn(0, 1, 32'h0, 32'h7000, 128'h0, 32'hC0, 3, -1, 2'b00, 60, -1, -1);
        run_txn(0, 1, 32'h0, 32'h7040, 128'h0, 32'hD0, BEATS, -1, 2'b00, 40, -1, -1);
        run_txn(0, 1, 32'h0, 32'h7080, 128'h0, 32'hE0, BEATS + 1, -1, 2'b00, 70, -1, -1);
        run_txn(0, 1, 32'h0, 32'h70C0, 128'h0, 32'hF0, BEATS, 2, 2'b00, 100, -1, -1);
        reset_mid_write();
        run_txn(0, 1, 32'h0, 32'h8000, 128'h0, 32'h55, BEATS, -1, 2'b00, 100, -1, BEATS + 2);

        for (int t = 0; t < 30; t++) begin
            kind = int'($urandom_range(2));
            case ($urandom_range(4))
                0: nb = 3;
                1: nb = 5;
                default: nb = BEATS;
            endcase
            run_txn(kind != 1, kind != 0, $urandom, $urandom,
                    {$urandom, $urandom, $urandom, $urandom}, $urandom, nb,
                    ($urandom_range(5) == 0) ? int'($urandom_range(3)) : -1,
                    ($urandom_range(3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                    int'($urandom_range(30, 100)), int'($urandom_range(4)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
